sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one synchronous single-port SRAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage), for a memory map with unified instruction and data storage. Data requests win contention by default. A starvation counter guarantees instruction fetch a grant after a bounded run of data grants. Issue is one request per cycle with a fixed one-cycle response, and the block routes each response back to its owner.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive contended data grants allowed before instruction fetch is forced a grant; legal range 1–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` in 1: instruction read request, held until accepted.
- `inst_addr` in 32: fetch address.
- `inst_cancel` in 1: IF flush; kills instruction traffic in this cycle.
- `inst_addr_ok` out 1: instruction request accepted this cycle.
- `inst_data_ok` out 1: instruction read data valid this cycle.
- `inst_rdata` out 32: fetched word.
- `data_req` in 1: data request, held until accepted.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_wstrb` in 4: byte strobes for a store.
- `data_addr` in 32: data address.
- `data_wdata` in 32: store data.
- `data_addr_ok` out 1: data request accepted this cycle.
- `data_data_ok` out 1: data response this cycle; issued for both loads and stores.
- `data_rdata` out 32: load data.
- `sram_en` out 1: SRAM enable.
- `sram_we` out 4: SRAM byte write enables.
- `sram_addr` out 32: SRAM address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid the cycle after `sram_en`.

## Operation
- Grant selection in cycle T is combinational from the requests, `inst_cancel` and registered state.
- Candidate inst means `inst_req & ~inst_cancel`.
- Only data requests: grant data.
- Only a candidate inst: grant inst.
- Both: grant inst if `starve_cnt == STARVE_LIMIT`, otherwise grant data.
- Granted side gets `addr_ok = 1`. `sram_en = 1` and the granted address drives `sram_addr`.
- Data grant: `sram_we = data_wr ? data_wstrb : 4'b0` and `sram_wdata = data_wdata`.
- Inst grant: `sram_we = 0` and `sram_wdata = 0`.
- No grant: `sram_en = 0` and all other SRAM outputs are 0.
- `starve_cnt` is 4 bits:
  - Increments on a data grant while a candidate inst is not granted.
  - Clears on any inst grant.
  - Holds otherwise.
  - Saturates at `STARVE_LIMIT`.
- Response registers are `resp_vld` and `resp_own` (inst/data), both loaded at the end of every cycle from that cycle's grant.
- Response cycle T+1:
  - `data_data_ok = resp_vld & resp_own==DATA`.
  - `inst_data_ok = resp_vld & resp_own==INST & ~inst_cancel`.
- `*_rdata` equals `sram_rdata` when the matching `*_data_ok` is 1, otherwise 0.
- A new grant may issue in the same cycle a response returns. Throughput is 1 per cycle.
- Requesters must accept `data_ok` unconditionally; there is no response back-pressure.

## Timing
- Reset (async assert, sync release):
  - `resp_vld = 0`, `resp_own = INST`, `starve_cnt = 0`.
  - All outputs are 0 while `resetn = 0`, since grants are masked during reset.
- Latency: `addr_ok` in T, `data_ok` in T+1, fixed.
- `inst_cancel` in T:
  - No inst grant in T.
  - Any inst response in T is suppressed (the read still completed in SRAM).
  - A data grant or data response in the same cycle is unaffected.
- Reset asserted mid-transaction: the in-flight response is dropped and no `data_ok` is produced after release.
- Requests dropped by the requester before `addr_ok` are legal and simply not granted.
- `starve_cnt` and the grant decision are consistent within a cycle; the counter updates at the edge.

## Structure
- Shared constants go in `constants.h`: owner encodings (`OWN_INST`, `OWN_DATA`) and the default `STARVE_LIMIT`.
- One natural sub-module, `sram_arb_prio`: grant selection plus the starvation counter.
- The top contains the response registers and the SRAM and response muxing.

## Test plan
- Data only: `data_req` store at 0x100 with wstrb 4'b0011 → `sram_we = 4'b0011` in T, `data_data_ok = 1` in T+1, inst outputs stay 0.
- Back-to-back inst fetches at 0x1c000000 and 0x1c000004, SRAM returns 0xAAAA/0xBBBB → `addr_ok` on both cycles, `inst_data_ok` in T+1 and T+2 with matching rdata.
- `STARVE_LIMIT = 4`, both requesting continuously → grant pattern D,D,D,D,I repeating; `starve_cnt` 0→4, then cleared.
- Inst granted in T, `inst_cancel = 1` in T+1 while data requests → `inst_data_ok = 0`, `data_addr_ok = 1` in T+1.
- `resetn` pulled low for 1 cycle right after a data load grant → no `data_data_ok` afterwards, all outputs 0 during reset, normal grant on the first request after release.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg
//   Shared definitions for the IF/MEM single-port SRAM arbiter:
//   response owner encoding, starvation counter width and the default
//   starvation limit.
`timescale 1ns/1ps
package sram_port_arbiter_pkg;

  // Owner of an in-flight SRAM access; selects which requester sees data_ok.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } own_e;

  // Width of the starvation counter (holds 0..15).
  localparam int CNT_W = 4;

  // Consecutive contended data grants before instruction fetch is forced.
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_arb_prio.sv
// sram_arb_prio
//   Grant selection between instruction fetch and data access plus the
//   starvation counter that bounds how long fetch can lose to data.
//
//   Ports:
//     clk          in   clock, rising edge
//     resetn       in   asynchronous active-low reset; also masks grants
//     inst_req     in   instruction request
//     inst_cancel  in   IF flush; removes the instruction candidate
//     data_req     in   data request
//     grant_inst   out  instruction side granted this cycle
//     grant_data   out  data side granted this cycle
//     starve_cnt   out  contended data grants since last instruction grant
`timescale 1ns/1ps
module sram_arb_prio
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic             inst_cancel,
  input  logic             data_req,
  output logic             grant_inst,
  output logic             grant_data,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic cand_inst;
  logic starved;

  // Counter never passes the limit, so equality marks the forced-fetch case.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] r;
    if (v >= lim) r = lim;
    else          r = v + CNT_W'(1);
    return r;
  endfunction

  assign cand_inst = inst_req & ~inst_cancel;
  assign starved   = (starve_cnt == LIMIT);

  // Grants are masked while reset is asserted so every output reads 0.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn) begin
      if (data_req && cand_inst) begin
        if (starved) grant_inst = 1'b1;
        else         grant_data = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end else if (cand_inst) begin
        grant_inst = 1'b1;
      end
    end
  end

  // Counts only data grants that actually displaced a fetch candidate.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (grant_inst) begin
      starve_cnt <= '0;
    end else if (grant_data && cand_inst) begin
      starve_cnt <= sat_inc(starve_cnt, LIMIT);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one synchronous single-port SRAM between instruction fetch and
//   data access. One grant per cycle, response fixed one cycle later and
//   routed back to the requester that owned the access.
//
//   Ports:
//     clk, resetn                     clock / async active-low reset
//     inst_req, inst_addr             instruction read request
//     inst_cancel                     IF flush (kills grant and response)
//     inst_addr_ok                    instruction accepted this cycle
//     inst_data_ok, inst_rdata        instruction response
//     data_req, data_wr, data_wstrb,  data request (load or store)
//     data_addr, data_wdata
//     data_addr_ok                    data accepted this cycle
//     data_data_ok, data_rdata        data response (loads and stores)
//     sram_en, sram_we, sram_addr,    SRAM command
//     sram_wdata
//     sram_rdata                      SRAM read data, one cycle after sram_en
`timescale 1ns/1ps
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  logic             grant_inst;
  logic             grant_data;
  logic [CNT_W-1:0] starve_cnt;
  logic             resp_vld;
  own_e             resp_own;

  sram_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_cancel (inst_cancel),
    .data_req    (data_req),
    .grant_inst  (grant_inst),
    .grant_data  (grant_data),
    .starve_cnt  (starve_cnt)
  );

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // Issue stage: drive the SRAM from the winner; idle cycles drive all zeros.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0;
    sram_addr  = 32'b0;
    sram_wdata = 32'b0;
    if (grant_data) begin
      sram_en    = 1'b1;
      sram_we    = data_wr ? data_wstrb : 4'b0;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (grant_inst) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  // Issue -> response boundary: remember whether and for whom SRAM was read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_vld <= 1'b0;
      resp_own <= OWN_INST;
    end else begin
      resp_vld <= grant_inst | grant_data;
      resp_own <= grant_data ? OWN_DATA : OWN_INST;
    end
  end

  // Response stage: a flush in the return cycle drops the fetched word
  // even though the SRAM read already happened.
  always_comb begin
    data_data_ok = resp_vld && (resp_own == OWN_DATA);
    inst_data_ok = resp_vld && (resp_own == OWN_INST) && !inst_cancel;
    data_rdata   = data_data_ok ? sram_rdata : 32'b0;
    inst_rdata   = inst_data_ok ? sram_rdata : 32'b0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks   = 0;
  int failures = 0;

  sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h1c00_0000;
    inst_cancel = 1'b0;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_wstrb  = 4'hf;
    data_addr   = 32'h0000_0040;
    data_wdata  = 32'h1111_2222;
    sram_rdata  = 32'hFFFF_FFFF;

    // Reset: requests present but everything masked.
    #2;
    chk("rst_sram_en",      32'(sram_en),      32'd0);
    chk("rst_sram_we",      32'(sram_we),      32'd0);
    chk("rst_sram_addr",    sram_addr,         32'd0);
    chk("rst_sram_wdata",   sram_wdata,        32'd0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("rst_data_rdata",   data_rdata,        32'd0);
    chk("rst_inst_rdata",   inst_rdata,        32'd0);
    chk("rst_starve_cnt",   32'(dut.u_prio.starve_cnt), 32'd0);
    inst_req = 1'b0;
    data_req = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;

    // Data-only store at 0x100, wstrb 0011.
    cyc();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("st_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("st_sram_en",      32'(sram_en),      32'd1);
    chk("st_sram_we",      32'(sram_we),      32'h3);
    chk("st_sram_addr",    sram_addr,         32'h0000_0100);
    chk("st_sram_wdata",   sram_wdata,        32'hDEAD_BEEF);
    cyc();
    data_req   = 1'b0;
    sram_rdata = 32'h1234_5678;
    #1;
    chk("st_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("st_data_rdata",   data_rdata,        32'h1234_5678);
    chk("st_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("st_inst_rdata",   inst_rdata,        32'd0);
    chk("st_idle_sram_en", 32'(sram_en),      32'd0);
    chk("st_idle_addr",    sram_addr,         32'd0);

    // Back-to-back instruction fetches.
    cyc();
    inst_req  = 1'b1;
    inst_addr = 32'h1c00_0000;
    #1;
    chk("if0_addr_ok",    32'(inst_addr_ok), 32'd1);
    chk("if0_sram_addr",  sram_addr,         32'h1c00_0000);
    chk("if0_sram_we",    32'(sram_we),      32'd0);
    chk("if0_sram_wdata", sram_wdata,        32'd0);
    chk("if0_data_ok",    32'(data_data_ok), 32'd0);
    cyc();
    inst_addr  = 32'h1c00_0004;
    sram_rdata = 32'h0000_AAAA;
    #1;
    chk("if1_addr_ok",   32'(inst_addr_ok), 32'd1);
    chk("if1_sram_addr", sram_addr,         32'h1c00_0004);
    chk("if1_data_ok",   32'(inst_data_ok), 32'd1);
    chk("if1_rdata",     inst_rdata,        32'h0000_AAAA);
    chk("if1_d_data_ok", 32'(data_data_ok), 32'd0);
    chk("if1_d_rdata",   data_rdata,        32'd0);
    cyc();
    inst_req   = 1'b0;
    sram_rdata = 32'h0000_BBBB;
    #1;
    chk("if2_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("if2_data_ok", 32'(inst_data_ok), 32'd1);
    chk("if2_rdata",   inst_rdata,        32'h0000_BBBB);
    cyc();
    #1;
    chk("if3_data_ok", 32'(inst_data_ok), 32'd0);
    chk("if3_rdata",   inst_rdata,        32'd0);

    // Starvation: both request continuously, pattern D,D,D,D,I.
    inst_req  = 1'b1;
    inst_addr = 32'h1c00_0100;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("sv%0d_data_addr_ok", i), 32'(data_addr_ok), (i % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("sv%0d_inst_addr_ok", i), 32'(inst_addr_ok), (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("sv%0d_starve_cnt", i),   32'(dut.u_prio.starve_cnt), 32'(i % 5));
      if (i > 0)
        chk($sformatf("sv%0d_data_data_ok", i), 32'(data_data_ok), (i % 5 == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    cyc();

    // Inst granted in T, cancel in T+1 while data requests.
    inst_req  = 1'b1;
    inst_addr = 32'h1c00_0200;
    #1;
    chk("cx0_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    cyc();
    inst_cancel = 1'b1;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_addr   = 32'h0000_0300;
    sram_rdata  = 32'h0000_CAFE;
    #1;
    chk("cx1_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("cx1_inst_rdata",   inst_rdata,        32'd0);
    chk("cx1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("cx1_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("cx1_sram_addr",    sram_addr,         32'h0000_0300);
    chk("cx1_starve_cnt",   32'(dut.u_prio.starve_cnt), 32'd0);
    cyc();
    inst_req   = 1'b0;
    data_req   = 1'b0;
    sram_rdata = 32'h0000_5555;
    #1;
    chk("cx2_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("cx2_data_rdata",   data_rdata,        32'h0000_5555);
    chk("cx2_starve_cnt",   32'(dut.u_prio.starve_cnt), 32'd0);
    cyc();
    inst_cancel = 1'b0;

    // Reset right after a data load grant.
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0400;
    #1;
    chk("rm0_data_addr_ok", 32'(data_addr_ok), 32'd1);
    cyc();
    resetn   = 1'b0;
    inst_req = 1'b1;
    #1;
    chk("rm1_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("rm1_data_rdata",   data_rdata,        32'd0);
    chk("rm1_sram_en",      32'(sram_en),      32'd0);
    chk("rm1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("rm1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    cyc();
    resetn   = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    #1;
    chk("rm2_data_data_ok", 32'(data_data_ok), 32'd0);
    cyc();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'hf;
    data_addr  = 32'h0000_0500;
    data_wdata = 32'h0BAD_F00D;
    #1;
    chk("rm3_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("rm3_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("rm3_sram_we",      32'(sram_we),      32'hf);
    chk("rm3_sram_wdata",   sram_wdata,        32'h0BAD_F00D);
    cyc();
    data_req = 1'b0;
    #1;
    chk("rm4_data_data_ok", 32'(data_data_ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
